// File: rtl/motor_speed_pi_if.sv
// Controller-side signal bundle for motor_speed_pi: speed feedback, target and gains in;
// duty command, PWM and update status out.
interface motor_speed_pi_if;
    logic        enable;
    logic [15:0] edge_in;
    logic        edge_valid;
    logic [15:0] target;
    logic [7:0]  kp;
    logic [7:0]  ki;
    logic [15:0] duty_cmd;
    logic        pwm_out;
    logic        busy;
    logic        done;

    modport master (
        output enable, edge_in, edge_valid, target, kp, ki,
        input  duty_cmd, pwm_out, busy, done
    );

    modport slave (
        input  enable, edge_in, edge_valid, target, kp, ki,
        output duty_cmd, pwm_out, busy, done
    );
endinterface

// File: rtl/motor_speed_pi.sv
// Multi-cycle PI speed controller with saturating integrator and a period-aligned PWM
// generator whose duty only changes at counter wrap.
module motor_speed_pi #(
    parameter int unsigned PWM_MAX   = 1249,
    parameter int unsigned SHIFT     = 4,
    parameter int unsigned INTEG_LIM = 1048576
) (
    input  logic             clk,
    input  logic             n_rst,
    motor_speed_pi_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ERR  = 3'd1,
        MUL  = 3'd2,
        ACC  = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam logic signed [25:0] LIM_P     = 26'(INTEG_LIM);
    localparam logic signed [25:0] LIM_N     = -LIM_P;
    localparam logic signed [25:0] PWM_MAX_S = 26'(PWM_MAX);
    localparam logic [15:0]        PWM_MAX_V = 16'(PWM_MAX);

    state_t             state_r;
    logic [15:0]        edge_r;
    logic [15:0]        target_r;
    logic [7:0]         kp_r;
    logic [7:0]         ki_r;
    logic signed [16:0] err_r;
    logic signed [24:0] p_r;
    logic signed [24:0] iterm_r;
    logic signed [23:0] integ_r;
    logic signed [25:0] sum_r;
    logic [15:0]        duty_cmd_r;
    logic               busy_r;
    logic               done_r;
    logic [15:0]        pwm_cnt_r;
    logic [15:0]        duty_act_r;
    logic               pwm_out_r;

    logic signed [24:0] err_x_s;
    logic signed [24:0] kp_x_s;
    logic signed [24:0] ki_x_s;
    logic signed [24:0] p_s;
    logic signed [24:0] iterm_s;
    logic signed [25:0] integ_sum_s;
    logic signed [23:0] integ_next_s;
    logic signed [25:0] sum_next_s;
    logic signed [25:0] shifted_s;

    function automatic logic signed [23:0] sat_integ(input logic signed [25:0] v);
        logic signed [25:0] r;
        if (v > LIM_P) begin
            r = LIM_P;
        end else if (v < LIM_N) begin
            r = LIM_N;
        end else begin
            r = v;
        end
        return r[23:0];
    endfunction

    function automatic logic [15:0] clamp_duty(input logic signed [25:0] s);
        logic [15:0] r;
        if (s < 26'sd0) begin
            r = 16'd0;
        end else if (s > PWM_MAX_S) begin
            r = PWM_MAX_V;
        end else begin
            r = s[15:0];
        end
        return r;
    endfunction

    // Widths chosen so err*gain and p+integ cannot overflow at full-scale inputs.
    assign err_x_s      = 25'(err_r);
    assign kp_x_s       = 25'($signed({1'b0, kp_r}));
    assign ki_x_s       = 25'($signed({1'b0, ki_r}));
    assign p_s          = err_x_s * kp_x_s;
    assign iterm_s      = err_x_s * ki_x_s;
    assign integ_sum_s  = 26'(integ_r) + 26'(iterm_r);
    assign integ_next_s = sat_integ(integ_sum_s);
    assign sum_next_s   = 26'(integ_next_s) + 26'(p_r);
    assign shifted_s    = sum_r >>> SHIFT;

    // PI update sequencer; enable low aborts any in-flight update and clears the integrator.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r    <= IDLE;
            edge_r     <= 16'd0;
            target_r   <= 16'd0;
            kp_r       <= 8'd0;
            ki_r       <= 8'd0;
            err_r      <= 17'sd0;
            p_r        <= 25'sd0;
            iterm_r    <= 25'sd0;
            integ_r    <= 24'sd0;
            sum_r      <= 26'sd0;
            duty_cmd_r <= 16'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (!bus.enable) begin
            state_r    <= IDLE;
            integ_r    <= 24'sd0;
            duty_cmd_r <= 16'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.edge_valid) begin
                        edge_r   <= bus.edge_in;
                        target_r <= bus.target;
                        kp_r     <= bus.kp;
                        ki_r     <= bus.ki;
                        busy_r   <= 1'b1;
                        state_r  <= ERR;
                    end
                end
                ERR: begin
                    err_r   <= $signed({1'b0, target_r}) - $signed({1'b0, edge_r});
                    state_r <= MUL;
                end
                MUL: begin
                    p_r     <= p_s;
                    iterm_r <= iterm_s;
                    state_r <= ACC;
                end
                ACC: begin
                    integ_r <= integ_next_s;
                    sum_r   <= sum_next_s;
                    state_r <= OUT;
                end
                OUT: begin
                    duty_cmd_r <= clamp_duty(shifted_s);
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Free-running PWM; duty_act reloads only at wrap so a period is never cut short.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pwm_cnt_r  <= 16'd0;
            duty_act_r <= 16'd0;
            pwm_out_r  <= 1'b0;
        end else begin
            if (pwm_cnt_r == PWM_MAX_V) begin
                pwm_cnt_r  <= 16'd0;
                duty_act_r <= duty_cmd_r;
            end else begin
                pwm_cnt_r  <= pwm_cnt_r + 16'd1;
            end
            pwm_out_r <= bus.enable && (pwm_cnt_r < duty_act_r);
        end
    end

    assign bus.duty_cmd = duty_cmd_r;
    assign bus.pwm_out  = pwm_out_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_motor_speed_pi.sv
// Directed bench for motor_speed_pi: table of PI vectors with hand-computed duties,
// plus sequences for PWM alignment, integrator saturation and abort behaviour.
module tb_motor_speed_pi;

    localparam int PWM_MAX   = 1249;
    localparam int INTEG_LIM = 1048576;

    logic clk;
    logic n_rst;
    int   tests;
    int   fails;

    motor_speed_pi_if bus();

    motor_speed_pi dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [15:0] target;
        logic [15:0] edge_in;
        logic [7:0]  kp;
        logic [7:0]  ki;
        int          exp_duty;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_ctrl();
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1;
    endtask

    // Strobe one update and return the done latency (0 = timed out); ends at the done negedge.
    task automatic run_update(input vec_t v, input bit at_now, output int lat, output int busy_seen);
        if (!at_now) @(negedge clk);
        bus.target     = v.target;
        bus.edge_in    = v.edge_in;
        bus.kp         = v.kp;
        bus.ki         = v.ki;
        bus.edge_valid = 1'b1;
        @(negedge clk);
        bus.edge_valid = 1'b0;
        busy_seen = int'(bus.busy);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    // Count pwm_out highs over one full period starting at the next counter wrap.
    task automatic count_period(output int n);
        int found;
        found = 0;
        n = 0;
        for (int k = 0; k < 1300; k++) begin
            if (dut.pwm_cnt_r == 16'd0) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (found == 0) begin
            n = -1;
        end else begin
            for (int k = 0; k < PWM_MAX + 1; k++) begin
                @(negedge clk);
                n += int'(bus.pwm_out);
            end
        end
    endtask

    initial begin
        int   lat;
        int   bsy;
        int   n;
        int   bad;
        int   dones;
        vec_t v;

        tests = 0;
        fails = 0;
        vecs[0]  = '{1'b1, 16'd200,   16'd100,  8'd16,  8'd0,   100};
        vecs[1]  = '{1'b1, 16'd110,   16'd100,  8'd0,   8'd16,  10};
        vecs[2]  = '{1'b0, 16'd110,   16'd100,  8'd0,   8'd16,  20};
        vecs[3]  = '{1'b0, 16'd110,   16'd100,  8'd0,   8'd16,  30};
        vecs[4]  = '{1'b1, 16'd65535, 16'd0,    8'd255, 8'd0,   1249};
        vecs[5]  = '{1'b0, 16'd0,     16'd5000, 8'd255, 8'd0,   0};
        vecs[6]  = '{1'b1, 16'd1000,  16'd0,    8'd0,   8'd0,   0};
        vecs[7]  = '{1'b1, 16'd500,   16'd500,  8'd100, 8'd100, 0};
        vecs[8]  = '{1'b1, 16'd0,     16'd1,    8'd1,   8'd0,   0};
        vecs[9]  = '{1'b1, 16'd31,    16'd0,    8'd1,   8'd0,   1};
        vecs[10] = '{1'b1, 16'd78,    16'd0,    8'd255, 8'd0,   1243};
        vecs[11] = '{1'b1, 16'd79,    16'd0,    8'd255, 8'd0,   1249};
        vecs[12] = '{1'b1, 16'd150,   16'd50,   8'd10,  8'd5,   93};
        vecs[13] = '{1'b0, 16'd150,   16'd50,   8'd10,  8'd5,   125};
        vecs[14] = '{1'b0, 16'd50,    16'd150,  8'd10,  8'd5,   0};
        vecs[15] = '{1'b1, 16'd65535, 16'd0,    8'd255, 8'd255, 1249};

        // Reset with strobes toggling: nothing may start.
        n_rst = 1'b0;
        bus.enable = 1'b1;
        bus.edge_valid = 1'b0;
        bus.edge_in = 16'd100;
        bus.target = 16'd200;
        bus.kp = 8'd16;
        bus.ki = 8'd16;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.edge_valid = ~bus.edge_valid;
        end
        @(negedge clk);
        check("rst_duty",  int'(bus.duty_cmd), 0);
        check("rst_pwm",   int'(bus.pwm_out), 0);
        check("rst_busy",  int'(bus.busy), 0);
        check("rst_done",  int'(bus.done), 0);
        check("rst_integ", int'(dut.integ_r), 0);
        check("rst_state", int'(dut.state_r), 0);
        check("rst_cnt",   int'(dut.pwm_cnt_r), 0);
        n_rst = 1'b1;
        bus.edge_valid = 1'b0;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].clr) clear_ctrl();
            run_update(vecs[i], 1'b0, lat, bsy);
            check($sformatf("v%0d_latency", i), lat, 4);
            check($sformatf("v%0d_busy", i), bsy, 1);
            check($sformatf("v%0d_duty", i), int'(bus.duty_cmd), vecs[i].exp_duty);
            @(negedge clk);
            check($sformatf("v%0d_done_len", i), int'(bus.done), 0);
        end

        // Proportional duty 100 on the PWM, then an update landing on the wrap cycle.
        clear_ctrl();
        v = '{1'b0, 16'd200, 16'd100, 8'd16, 8'd0, 100};
        run_update(v, 1'b0, lat, bsy);
        count_period(n);
        check("pwm_duty100", n, 100);
        bad = 1;
        for (int k = 0; k < 1300; k++) begin
            if (int'(dut.pwm_cnt_r) == PWM_MAX - 4) begin
                bad = 0;
                break;
            end
            @(negedge clk);
        end
        check("wrap_sync", bad, 0);
        v = '{1'b0, 16'd300, 16'd100, 8'd16, 8'd0, 200};
        run_update(v, 1'b1, lat, bsy);
        check("wrap_latency", lat, 4);
        check("wrap_duty_cmd", int'(bus.duty_cmd), 200);
        check("wrap_duty_act", int'(dut.duty_act_r), 100);
        count_period(n);
        check("wrap_old_period", n, 100);
        count_period(n);
        check("wrap_new_period", n, 200);

        // Duty 0 keeps the output low for a whole period.
        v = '{1'b0, 16'd0, 16'd5000, 8'd255, 8'd0, 0};
        run_update(v, 1'b0, lat, bsy);
        check("zero_duty", int'(bus.duty_cmd), 0);
        count_period(n);
        check("pwm_duty0", n, 0);

        // Integrator saturates at +limit and never wraps negative.
        clear_ctrl();
        v = '{1'b0, 16'd65535, 16'd0, 8'd0, 8'd255, 1249};
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            run_update(v, 1'b0, lat, bsy);
            if (lat != 4 || int'(dut.integ_r) < 0 || int'(dut.integ_r) > INTEG_LIM) bad++;
        end
        check("integ_bounded", bad, 0);
        check("integ_at_limit", int'(dut.integ_r), INTEG_LIM);
        check("integ_sat_duty", int'(bus.duty_cmd), 1249);
        v = '{1'b0, 16'd0, 16'd65535, 8'd0, 8'd1, 0};
        for (int k = 1; k <= 3; k++) begin
            run_update(v, 1'b0, lat, bsy);
            check($sformatf("unwind_%0d", k), int'(dut.integ_r), INTEG_LIM - 65535 * k);
        end

        // Full duty, then abort an update with enable low at t+2.
        v = '{1'b0, 16'd65535, 16'd0, 8'd255, 8'd16, 1249};
        run_update(v, 1'b0, lat, bsy);
        count_period(n);
        check("pwm_duty_max", n, PWM_MAX);
        @(negedge clk);
        bus.edge_valid = 1'b1;
        @(negedge clk);
        bus.edge_valid = 1'b0;
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        check("abort_busy",  int'(bus.busy), 0);
        check("abort_done",  int'(bus.done), 0);
        check("abort_duty",  int'(bus.duty_cmd), 0);
        check("abort_integ", int'(dut.integ_r), 0);
        check("abort_pwm",   int'(bus.pwm_out), 0);
        check("abort_state", int'(dut.state_r), 0);
        bus.enable = 1'b1;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        check("abort_no_done", dones, 0);

        // A second strobe at t+2 is dropped.
        clear_ctrl();
        @(negedge clk);
        bus.target = 16'd200;
        bus.edge_in = 16'd100;
        bus.kp = 8'd16;
        bus.ki = 8'd0;
        bus.edge_valid = 1'b1;
        dones = 0;
        @(negedge clk);
        bus.edge_valid = 1'b0;
        @(negedge clk);
        bus.target = 16'd1000;
        bus.edge_in = 16'd0;
        bus.kp = 8'd255;
        bus.edge_valid = 1'b1;
        @(negedge clk);
        bus.edge_valid = 1'b0;
        dones += int'(bus.done);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        check("drop_dones", dones, 1);
        check("drop_duty", int'(bus.duty_cmd), 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/motor_speed_pi.md
# motor_speed_pi

Closed-loop motor speed controller sitting directly downstream of the feedback edge counter. Each time the counter publishes a new per-window edge count, the block runs a multi-cycle PI update against the target count. It produces a saturated duty command and drives the motor PWM output from that command. Duty changes are applied only at PWM period boundaries, so pulses are never truncated.

## Interface
- PWM_MAX, 1249: PWM counter terminal value; period = PWM_MAX+1 clk cycles (100 kHz at 125 MHz).
- SHIFT, 4: arithmetic right shift applied to the PI sum (gain fraction bits).
- INTEG_LIM, 1048576: symmetric integrator saturation limit, ±INTEG_LIM.

- clk  in  1  system clock, 125 MHz.
- n_rst  in  1  reset, synchronous, active-low.
- enable  in  1  controller enable; low forces idle, clears integrator, gates PWM.
- edge_in  in  16  unsigned edge count for the last window (measured speed).
- edge_valid  in  1  one-cycle strobe; edge_in holds a fresh value this cycle.
- target  in  16  unsigned target edge count per window.
- kp  in  8  unsigned proportional gain.
- ki  in  8  unsigned integral gain.
- duty_cmd  out  16  current computed duty, 0..PWM_MAX.
- pwm_out  out  1  motor PWM.
- busy  out  1  high while an update is in progress.
- done  out  1  one-cycle pulse when duty_cmd is updated.

## Operation
- FSM states: IDLE, ERR, MUL, ACC, OUT.
- IDLE: on edge_valid && enable, latch edge_in, target, kp, ki → ERR. edge_valid in any other state is dropped, with no queuing.
- ERR: err = $signed({1'b0,target}) − $signed({1'b0,edge_in}), 17-bit signed → MUL.
- MUL: p = err*kp and iterm = err*ki, 25-bit signed each, registered → ACC.
- ACC: integ = sat(integ + iterm, ±INTEG_LIM); integ is a 24-bit signed register. sum = p + new integ, 26-bit signed → OUT.
- OUT: s = sum >>> SHIFT (arithmetic, floor). Clamp: s<0 → 0; s>PWM_MAX → PWM_MAX. Write duty_cmd, pulse done → IDLE.
- PWM: pwm_cnt counts 0..PWM_MAX and wraps; runs whenever out of reset, regardless of enable.
- duty_act is loaded from duty_cmd in the cycle pwm_cnt==PWM_MAX.
- pwm_out = enable_r && (pwm_cnt < duty_act), registered.
- duty 0 → constant low. duty PWM_MAX → high PWM_MAX of PWM_MAX+1 cycles.
- enable low (any state): next cycle FSM=IDLE, integ=0, duty_cmd=0, busy=0, done=0, pwm_out=0. An in-flight update is discarded.
- Gains of 0 are legal. kp=ki=0 yields duty 0.

## Timing
- Reset values: duty_cmd=0, pwm_out=0, busy=0, done=0, integ=0, pwm_cnt=0, duty_act=0, FSM=IDLE.
- edge_valid sampled at edge t. busy high from t+1 through t+4. duty_cmd and done valid after edge t+4. Latency is 4 cycles.
- A new edge_valid is accepted at t+5 at the earliest. Back-to-back strobes inside t+1..t+4 are ignored.
- A new duty_cmd reaches pwm_out at the first pwm_cnt wrap after the update. pwm_out lags the counter compare by 1 cycle.
- Simultaneous duty_cmd update and pwm_cnt==PWM_MAX: duty_act loads the old duty_cmd. The new value applies one period later.
- Integrator saturates and never wraps. Sum and product widths are sized so they cannot overflow at max inputs.
- Reset or enable deassertion mid-update: takes effect on the next edge, with no done pulse.

## Test plan
- Reset: hold n_rst low 5 cycles with edge_valid toggling → all outputs 0, FSM IDLE, no done.
- Proportional: kp=16, ki=0, target=200, edge_in=100, one strobe → done at +4, duty_cmd=100. pwm_out is high 100 of 1250 cycles from the next period.
- Integral: kp=0, ki=16, target=110, edge_in=100, three strobes spaced 10 cycles → duty_cmd 10, 20, 30.
- Clamp: kp=255, target=65535, edge_in=0 → duty_cmd=1249. Then target=0, edge_in=5000, ki=0 → duty_cmd=0 and pwm_out constantly low.
- Integrator limit: ki=255, err=+65535 repeated 100 strobes → integ stops at 1048576 and never goes negative. Reversed error then unwinds it linearly.
- Boundary and abort: (a) update landing in the pwm_cnt==PWM_MAX cycle → old duty persists one extra period. (b) enable dropped at t+2 → no done, duty_cmd=0, integ=0, pwm_out low next cycle. (c) edge_valid at t+2 → ignored.
